// File: rtl/restrict_seq_det.sv
// restrict_seq_det: overlapping Moore detector for the serial pattern 1-0-1-1.
// A one-hot FSM tracks the longest matched prefix. detect_out is a registered
// flag that is high for one cycle, one edge after the FSM reaches the full-match state.
// Optional checks are compiled in when RESTRICT_SEQ_DET_ASSERT_EN is defined.
module restrict_seq_det (
    input  logic clk,
    input  logic reset,
    input  logic seq_in,
    output logic detect_out
);

    localparam int unsigned STATE_W = 5;

    typedef enum logic [STATE_W-1:0] {
        S0 = 5'b00001,  // idle / no useful prefix
        S1 = 5'b00010,  // seen "1"
        S2 = 5'b00100,  // seen "10"
        S3 = 5'b01000,  // seen "101"
        S4 = 5'b10000   // seen "1011"
    } state_e;

    state_e state_q, state_d;
    logic   detect_q, detect_d;

    // State and flag registers; synchronous reset discards any partial match.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S0;
            detect_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            detect_q <= detect_d;
        end
    end

    // Next-state and flag logic; S4 falls back to S1/S2 so matches may overlap.
    always_comb begin
        state_d  = S0;
        detect_d = (state_q == S4);
        case (state_q)
            S0:      state_d = seq_in ? S1 : S0;
            S1:      state_d = seq_in ? S1 : S2;
            S2:      state_d = seq_in ? S3 : S0;
            S3:      state_d = seq_in ? S4 : S2;
            S4:      state_d = seq_in ? S1 : S2;
            default: state_d = S0;
        endcase
    end

    assign detect_out = detect_q;

`ifdef RESTRICT_SEQ_DET_ASSERT_EN
    // Checker-only history of the bits sampled since the last reset.
    logic [3:0] chk_hist_q, chk_hist_d;
    logic [2:0] chk_cnt_q, chk_cnt_d;
    logic       chk_match_q, chk_match_d;
    logic       chk_started_q;

    // Shift in each sampled bit; chk_match_q marks the edge detect_out must rise.
    always_comb begin
        chk_hist_d  = {chk_hist_q[2:0], seq_in};
        chk_cnt_d   = (chk_cnt_q == 3'd4) ? chk_cnt_q : chk_cnt_q + 3'd1;
        chk_match_d = (chk_cnt_q == 3'd4) && (chk_hist_q == 4'b1011);
    end

    // History registers, cleared with the design.
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_hist_q  <= 4'b0000;
            chk_cnt_q   <= 3'd0;
            chk_match_q <= 1'b0;
        end else begin
            chk_hist_q  <= chk_hist_d;
            chk_cnt_q   <= chk_cnt_d;
            chk_match_q <= chk_match_d;
        end
    end

    // Marks that at least one edge has passed, for the initial-reset assumption.
    always_ff @(posedge clk) begin
        chk_started_q <= 1'b1;
    end

    a_state_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot(state_q));

    a_match_flags: assert property (@(posedge clk) disable iff (reset)
        chk_match_q |-> detect_out);

    a_no_back_to_back: assert property (@(posedge clk) disable iff (reset)
        detect_out |-> !$past(detect_out));

    c_match_seen: cover property (@(posedge clk) disable iff (reset)
        chk_match_q && detect_out);

    m_reset_first: assume property (@(posedge clk)
        !chk_started_q |-> reset);
`endif

endmodule

// File: tb/tb_restrict_seq_det.sv
// Testbench for restrict_seq_det: directed pattern cases plus a random bit
// stream, all compared with a queue-based reference of the last four bits.
module tb_restrict_seq_det;

    logic clk;
    logic reset;
    logic seq_in;
    logic detect_out;

    int unsigned total_cnt;
    int unsigned bad_cnt;

    // Reference model: bits sampled since the last reset, most recent last.
    bit  ref_bits[$];
    bit  ref_det;
    int  ref_pulses;
    int  dut_pulses;
    logic prev_det;

    restrict_seq_det dut (
        .clk        (clk),
        .reset      (reset),
        .seq_in     (seq_in),
        .detect_out (detect_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_full_match();
        int n;
        n = ref_bits.size();
        return (n >= 4) && ref_bits[n-4] && !ref_bits[n-3] && ref_bits[n-2] && ref_bits[n-1];
    endfunction

    // Apply one clock edge with the given inputs, update the model, compare.
    task automatic step(input logic rst, input logic bit_in);
        reset  = rst;
        seq_in = bit_in;
        @(posedge clk);
        #1;
        if (rst) begin
            ref_det = 1'b0;
            ref_bits.delete();
        end else begin
            // Flag follows "last four bits were 1011" one edge later.
            ref_det = ref_full_match();
            ref_bits.push_back(bit_in);
            if (ref_bits.size() > 4) void'(ref_bits.pop_front());
        end
        if (ref_det) ref_pulses++;
        if (detect_out === 1'b1) dut_pulses++;
        check_eq("detect_out", 32'(detect_out), 32'(ref_det));
        check_eq("no_back_to_back", 32'(prev_det & detect_out), 32'd0);
        prev_det = detect_out;
    endtask

    // Reset one edge, play a pattern, flush with zeros, check the pulse count.
    task automatic run_pattern(input string tag, input logic [6:0] bits, input int len, input int exp_pulses);
        int start;
        step(1'b1, 1'b0);
        start = dut_pulses;
        for (int i = len - 1; i >= 0; i--) step(1'b0, bits[i]);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        check_eq(tag, 32'(dut_pulses - start), 32'(exp_pulses));
    endtask

    initial begin
        total_cnt  = 0;
        bad_cnt    = 0;
        ref_det    = 1'b0;
        ref_pulses = 0;
        dut_pulses = 0;
        prev_det   = 1'b0;
        reset      = 1'b1;
        seq_in     = 1'b1;

        // Reset held over two edges with seq_in=1 ignored.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1);
            check_eq("reset_state", 32'(dut.state_q), 32'h01);
        end

        // Single match: pulse appears two edges after the last bit.
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check_eq("s4_reached", 32'(dut.state_q), 32'h10);
        check_eq("flag_low_E3", 32'(detect_out), 32'd0);
        step(1'b0, 1'b0);
        check_eq("flag_high_E4", 32'(detect_out), 32'd1);
        step(1'b0, 1'b0);
        check_eq("flag_low_E5", 32'(detect_out), 32'd0);

        run_pattern("pulses_1011011", 7'b1011011, 7, 2);
        run_pattern("pulses_1110111", 7'b1110111, 7, 1);
        run_pattern("pulses_1001011", 7'b1001011, 7, 1);
        run_pattern("pulses_101100",  7'b0101100, 6, 1);

        // Partial match discarded by a mid-stream reset.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check_eq("mid_reset_state", 32'(dut.state_q), 32'h01);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // Random stream with occasional resets.
        ref_pulses = 0;
        dut_pulses = 0;
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(499) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(1)));
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_eq("random_pulse_count", 32'(dut_pulses), 32'(ref_pulses));
        check_eq("random_had_pulses", 32'(ref_pulses > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
